// File: rtl/sha256_w_scheduler.sv
// SHA-256 message-schedule sequencer: loads one 512-bit block and streams W[0..63]
// over a valid/ready handshake, expanding W[16..63] in a 16-word sliding window.
module sha256_w_scheduler #(
  parameter int ROUNDS = 64,
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*WORD_W-1:0]  blk_data,
  output logic                  busy,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_out,
  output logic [5:0]            w_idx,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] win [16];
  logic [5:0]        t;
  logic [WORD_W-1:0] next_word;
  logic              accept;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[WORD_W-1:7]} ^ {x[17:0], x[WORD_W-1:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[WORD_W-1:17]} ^ {x[18:0], x[WORD_W-1:19]} ^ (x >> 10);
  endfunction

  // win[0] is W[t], so the new tail word is W[t+16]; sums wrap mod 2^32.
  assign next_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  assign accept    = (state == RUN) && w_ready;

  assign w_valid = (state == RUN);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign w_out   = win[0];
  assign w_idx   = t;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state is defaulted first so no path through this block leaves
  // state_nxt unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (accept && (t == 6'(ROUNDS - 1))) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the window is an architectural register file that must read as zero
  // after reset (w_out = win[0]), so it is reset explicitly, unlike a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      t <= '0;
    end else if (state == IDLE && start) begin
      for (int i = 0; i < 16; i++) win[i] <= blk_data[(15 - i)*WORD_W +: WORD_W];
      t <= '0;
    end else if (accept) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
      win[15] <= next_word;
      t       <= t + 6'd1;
    end
  end

endmodule

// File: tb/tb_sha256_w_scheduler.sv
// Scoreboard bench for sha256_w_scheduler: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted beat.
module tb_sha256_w_scheduler;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] w;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] blk_data;
  logic         busy, w_valid, w_ready, done;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;

  exp_t        sb[$];
  logic [31:0] mw [64];
  int          n_total = 0;
  int          n_pass  = 0;

  sha256_w_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .blk_data(blk_data), .busy(busy),
    .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out), .w_idx(w_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Golden schedule in the textbook array form.
  task automatic model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) mw[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) mw[i] = s1(mw[i-2]) + mw[i-7] + s0(mw[i-15]) + mw[i-16];
  endtask

  // Hand-computed "abc" words W0..W18.
  task automatic push_abc();
    logic [31:0] hand [19];
    for (int i = 0; i < 19; i++) hand[i] = 32'h0;
    hand[0]  = 32'h61626380;
    hand[15] = 32'h00000018;
    hand[16] = 32'h61626380;
    hand[17] = 32'h000F0000;
    hand[18] = 32'h7DA86405;
    model({32'h61626380, 448'h0, 32'h00000018});
    for (int i = 0; i < 64; i++) sb.push_back('{idx: 6'(i), w: (i < 19) ? hand[i] : mw[i]});
  endtask

  task automatic push_model(input logic [511:0] b);
    model(b);
    for (int i = 0; i < 64; i++) sb.push_back('{idx: 6'(i), w: mw[i]});
  endtask

  // Monitor: one comparison per accepted beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && w_valid && w_ready) begin
        if (sb.size() == 0) check("extra_beat", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("w_idx", 32'(w_idx), 32'(e.idx));
          check("w_out", w_out, e.w);
        end
      end
    end
  end

  // mode 0: ready high; 1: random ready; 2: 3-cycle stall at idx 17; 3: start pulse at idx 30.
  task automatic run_block(input logic [511:0] blk, input int mode);
    int accepts = 0;
    int cyc     = 0;
    int stalls  = 0;
    bit pulsed  = 0;
    blk_data = blk;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (accepts < 64 && cyc < 2000) begin
      start   = 1'b0;
      w_ready = 1'b1;
      if (mode == 1) w_ready = ($urandom_range(0, 9) < 7);
      if (mode == 2 && w_idx == 6'd17 && stalls < 3) begin
        w_ready = 1'b0;
        check("stall_w_out", w_out, 32'h000F0000);
        check("stall_w_idx", 32'(w_idx), 32'd17);
        check("stall_w_valid", 32'(w_valid), 32'd1);
        stalls++;
      end
      if (mode == 3 && w_idx == 6'd30 && !pulsed) begin
        start    = 1'b1;
        blk_data = ~blk;
        pulsed   = 1;
      end
      if (w_valid && w_ready) accepts++;
      @(posedge clk); #1;
      cyc++;
    end
    start   = 1'b0;
    w_ready = 1'b0;
    if (cyc >= 2000) check("block_timeout", 32'd1, 32'd0);
    if (mode == 0) check("consecutive_cycles", 32'(cyc), 32'd64);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    check("valid_after_last", 32'(w_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    check("done_fall", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [511:0] b;
    int cyc;
    rst = 1'b1; start = 1'b0; w_ready = 1'b0; blk_data = '0;
    #1;
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_w_out", w_out, 32'd0);
    check("rst_w_idx", 32'(w_idx), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // "abc" no stall, then back-to-back with backpressure.
    push_abc();
    run_block({32'h61626380, 448'h0, 32'h00000018}, 0);
    push_abc();
    run_block({32'h61626380, 448'h0, 32'h00000018}, 2);

    // Start while busy must not disturb the running block.
    b = {16{32'h01234567}} ^ {$urandom, $urandom, $urandom, $urandom, 384'h0};
    push_model(b);
    run_block(b, 3);

    // Mid-block reset at w_idx 40.
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_model(b);
    blk_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; w_ready = 1'b1; cyc = 0;
    while (w_idx != 6'd40 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_idx40", 32'(w_idx), 32'd40);
    w_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_w_valid", 32'(w_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_w_out", w_out, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    b = {16{32'hA5A55A5A}} ^ {8{$urandom, 32'h0}};
    push_model(b);
    run_block(b, 0);

    // Random blocks with random backpressure.
    for (int k = 0; k < 500; k++) begin
      b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      push_model(b);
      run_block(b, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
